// File: rtl/port_arbiter.sv
// Round-robin arbiter granting one of N_PORTS inputs ownership of a single output
// port for a whole packet; ownership ends on an accepted end-of-packet beat or an idle timeout.
module port_arbiter #(
  parameter int N_PORTS      = 4,
  parameter int IDLE_TIMEOUT = 16,
  localparam int ID_W        = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_PORTS-1:0] req,
  input  logic [N_PORTS-1:0] valid,
  input  logic [N_PORTS-1:0] eop,
  input  logic               out_ready,
  output logic [N_PORTS-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               busy,
  output logic               beat,
  output logic               timeout
);

  localparam int CNT_W = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t             state, state_d;
  logic [ID_W-1:0]    ptr, ptr_d;
  logic [CNT_W-1:0]   idle_cnt, idle_cnt_d;
  logic [N_PORTS-1:0] gnt_d;
  logic [ID_W-1:0]    gnt_id_d;
  logic               busy_d;
  logic               timeout_d;
  logic               post_reset;

  // Rotating search for the first requester at or after ptr.
  int                 scan_idx;
  logic [ID_W-1:0]    scan_id;
  logic [ID_W-1:0]    pick_id;
  logic               pick_found;
  logic [ID_W-1:0]    rel_ptr;
  logic               eop_beat;
  logic               idle_expired;

  assign beat         = busy & out_ready & valid[gnt_id];
  assign eop_beat     = beat & eop[gnt_id];
  assign idle_expired = (idle_cnt == CNT_W'(IDLE_TIMEOUT - 1));
  assign rel_ptr      = (gnt_id == ID_W'(N_PORTS - 1)) ? '0 : gnt_id + ID_W'(1);

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    scan_idx   = 0;
    scan_id    = '0;
    pick_id    = '0;
    pick_found = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      scan_idx = int'(ptr) + i;
      if (scan_idx >= N_PORTS) begin
        scan_idx = scan_idx - N_PORTS;
      end
      scan_id = scan_idx[ID_W-1:0];
      if (!pick_found && req[scan_id]) begin
        pick_found = 1'b1;
        pick_id    = scan_id;
      end
    end
  end

  always_comb begin
    state_d    = state;
    ptr_d      = ptr;
    idle_cnt_d = idle_cnt;
    gnt_d      = gnt;
    gnt_id_d   = gnt_id;
    busy_d     = busy;
    timeout_d  = 1'b0;

    unique case (state)
      IDLE: begin
        gnt_d      = '0;
        gnt_id_d   = '0;
        busy_d     = 1'b0;
        idle_cnt_d = '0;
        // The first cycle out of reset never grants, so req seen during reset is dropped.
        if (pick_found && !post_reset) begin
          state_d  = OWN;
          gnt_d    = N_PORTS'(1) << pick_id;
          gnt_id_d = pick_id;
          busy_d   = 1'b1;
        end
      end

      OWN: begin
        if (eop_beat || (!beat && idle_expired)) begin
          // eop wins over a simultaneous timeout, so the pulse only marks a true stall.
          state_d    = IDLE;
          ptr_d      = rel_ptr;
          idle_cnt_d = '0;
          gnt_d      = '0;
          gnt_id_d   = '0;
          busy_d     = 1'b0;
          timeout_d  = !eop_beat;
        end else if (beat) begin
          idle_cnt_d = '0;
        end else if (idle_cnt != CNT_W'(IDLE_TIMEOUT)) begin
          idle_cnt_d = idle_cnt + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      idle_cnt   <= '0;
      gnt        <= '0;
      gnt_id     <= '0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
      post_reset <= 1'b1;
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      idle_cnt   <= idle_cnt_d;
      gnt        <= gnt_d;
      gnt_id     <= gnt_id_d;
      busy       <= busy_d;
      timeout    <= timeout_d;
      post_reset <= 1'b0;
    end
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
  a_gnt_id_match: assert property (@(posedge clk) disable iff (reset)
    busy |-> (gnt == (N_PORTS'(1) << gnt_id)));

endmodule

// File: tb/tb_port_arbiter.sv
// Directed self-checking bench for port_arbiter: reset, packet grant/release,
// round-robin order, backpressure, idle timeout, mid-packet reset and non-owner noise.
module tb_port_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] valid;
  logic [3:0] eop;
  logic       out_ready;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       beat;
  logic       timeout;

  int n_checks = 0;
  int n_fails  = 0;

  port_arbiter #(.N_PORTS(4), .IDLE_TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .valid     (valid),
    .eop       (eop),
    .out_ready (out_ready),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .busy      (busy),
    .beat      (beat),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req       = 4'b0000;
    valid     = 4'b0000;
    eop       = 4'b0000;
    out_ready = 1'b1;
  endtask

  // One reset edge, then one quiet cycle so the post-reset hold has expired.
  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    req   = 4'b1111;
    tick();
    n_checks++;
    if (gnt !== 4'b0000) begin n_fails++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_checks++;
    if (gnt_id !== 2'd0) begin n_fails++; $display("FAIL reset_gnt_id: got %0d want 0", gnt_id); end
    n_checks++;
    if (busy !== 1'b0 || timeout !== 1'b0) begin
      n_fails++; $display("FAIL reset_busy_timeout: got busy=%b timeout=%b want 0 0", busy, timeout);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (gnt !== 4'b0000) begin n_fails++; $display("FAIL reset_first_edge_nogrant: got %b want 0000", gnt); end
    tick();
    n_checks++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
      n_fails++; $display("FAIL reset_second_edge_grant: got gnt=%b id=%0d want 0001 0", gnt, gnt_id);
    end
  endtask

  task automatic test_single_requester();
    apply_reset();
    req = 4'b0100;
    tick();
    n_checks++;
    if (gnt !== 4'b0100 || gnt_id !== 2'd2 || busy !== 1'b1) begin
      n_fails++; $display("FAIL single_grant: got gnt=%b id=%0d busy=%b want 0100 2 1", gnt, gnt_id, busy);
    end
    for (int b = 0; b < 3; b++) begin
      valid = 4'b0100;
      eop   = (b == 2) ? 4'b0100 : 4'b0000;
      #1;
      n_checks++;
      if (beat !== 1'b1) begin n_fails++; $display("FAIL single_beat%0d: got %b want 1", b, beat); end
      tick();
      if (b < 2) begin
        n_checks++;
        if (busy !== 1'b1) begin n_fails++; $display("FAIL single_hold%0d: busy got %b want 1", b, busy); end
      end
    end
    n_checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0) begin
      n_fails++; $display("FAIL single_release: got gnt=%b busy=%b to=%b want 0000 0 0", gnt, busy, timeout);
    end
    // ptr must now be 3: with ports 0,1,3 requesting, port 3 wins after the bubble.
    valid = 4'b0000;
    eop   = 4'b0000;
    req   = 4'b1011;
    tick();
    n_checks++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
      n_fails++; $display("FAIL single_ptr_next: got gnt=%b id=%0d want 1000 3", gnt, gnt_id);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt;
    apply_reset();
    req   = 4'b1111;
    valid = 4'b1111;
    eop   = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      exp_gnt = 4'b0001 << (k % 4);
      n_checks++;
      if (gnt !== exp_gnt || gnt_id !== 2'(k % 4)) begin
        n_fails++; $display("FAIL rr_grant%0d: got gnt=%b id=%0d want %b %0d", k, gnt, gnt_id, exp_gnt, k % 4);
      end
      n_checks++;
      if (beat !== 1'b1) begin n_fails++; $display("FAIL rr_beat%0d: got %b want 1", k, beat); end
      tick();
      n_checks++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || beat !== 1'b0) begin
        n_fails++; $display("FAIL rr_bubble%0d: got gnt=%b busy=%b beat=%b want 0000 0 0", k, gnt, busy, beat);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    apply_reset();
    req = 4'b0010;
    tick();
    n_checks++;
    if (gnt !== 4'b0010) begin n_fails++; $display("FAIL bp_grant: got %b want 0010", gnt); end
    valid = 4'b0010;
    for (int c = 0; c < 12 && accepted < 4; c++) begin
      out_ready = (c % 2 == 1);
      eop       = (accepted == 3) ? 4'b0010 : 4'b0000;
      #1;
      n_checks++;
      if (beat !== out_ready) begin
        n_fails++; $display("FAIL bp_beat_c%0d: got %b want %b", c, beat, out_ready);
      end
      tick();
      if (out_ready) accepted++;
      n_checks++;
      if (busy !== (accepted < 4) || timeout !== 1'b0) begin
        n_fails++; $display("FAIL bp_state_c%0d: got busy=%b to=%b want %b 0", c, busy, timeout, accepted < 4);
      end
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    req = 4'b0011;
    tick();
    n_checks++;
    if (gnt !== 4'b0001) begin n_fails++; $display("FAIL to_grant: got %b want 0001", gnt); end
    for (int c = 1; c <= 15; c++) begin
      tick();
      n_checks++;
      if (busy !== 1'b1 || timeout !== 1'b0) begin
        n_fails++; $display("FAIL to_wait%0d: got busy=%b to=%b want 1 0", c, busy, timeout);
      end
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || timeout !== 1'b1 || gnt !== 4'b0000) begin
      n_fails++; $display("FAIL to_fire: got busy=%b to=%b gnt=%b want 0 1 0000", busy, timeout, gnt);
    end
    tick();
    n_checks++;
    if (timeout !== 1'b0 || gnt !== 4'b0010) begin
      n_fails++; $display("FAIL to_next: got to=%b gnt=%b want 0 0010", timeout, gnt);
    end
    // Stall port 1 to the last idle cycle, then finish with eop on that very cycle.
    for (int c = 1; c <= 15; c++) tick();
    n_checks++;
    if (busy !== 1'b1) begin n_fails++; $display("FAIL to_prec_wait: busy got %b want 1", busy); end
    valid = 4'b0010;
    eop   = 4'b0010;
    #1;
    n_checks++;
    if (beat !== 1'b1) begin n_fails++; $display("FAIL to_prec_beat: got %b want 1", beat); end
    tick();
    n_checks++;
    if (busy !== 1'b0 || timeout !== 1'b0) begin
      n_fails++; $display("FAIL to_prec_release: got busy=%b to=%b want 0 0", busy, timeout);
    end
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    req = 4'b1000;
    tick();
    n_checks++;
    if (gnt !== 4'b1000) begin n_fails++; $display("FAIL rmid_grant: got %b want 1000", gnt); end
    valid = 4'b1000;
    tick();
    tick();
    reset = 1'b1;
    req   = 4'b1001;
    valid = 4'b0000;
    tick();
    n_checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0) begin
      n_fails++; $display("FAIL rmid_abort: got gnt=%b busy=%b to=%b want 0000 0 0", gnt, busy, timeout);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (gnt !== 4'b0000) begin n_fails++; $display("FAIL rmid_hold: got %b want 0000", gnt); end
    tick();
    n_checks++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
      n_fails++; $display("FAIL rmid_first: got gnt=%b id=%0d want 0001 0", gnt, gnt_id);
    end
  endtask

  task automatic test_non_owner_noise();
    apply_reset();
    req = 4'b0100;
    tick();
    // Owner drops req; ports 0/1 flood valid+eop.
    req   = 4'b0011;
    valid = 4'b0011;
    eop   = 4'b0011;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if (beat !== 1'b0) begin n_fails++; $display("FAIL noise_beat%0d: got %b want 0", c, beat); end
      tick();
      n_checks++;
      if (gnt !== 4'b0100 || busy !== 1'b1) begin
        n_fails++; $display("FAIL noise_hold%0d: got gnt=%b busy=%b want 0100 1", c, gnt, busy);
      end
    end
    valid = 4'b0111;
    #1;
    n_checks++;
    if (beat !== 1'b1) begin n_fails++; $display("FAIL noise_owner_beat: got %b want 1", beat); end
    tick();
    n_checks++;
    if (busy !== 1'b1) begin n_fails++; $display("FAIL noise_no_eop_hold: busy got %b want 1", busy); end
    eop = 4'b0100;
    tick();
    n_checks++;
    if (busy !== 1'b0 || gnt !== 4'b0000) begin
      n_fails++; $display("FAIL noise_release: got busy=%b gnt=%b want 0 0000", busy, gnt);
    end
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    #2;
    test_reset();
    test_single_requester();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_reset_mid_packet();
    test_non_owner_noise();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
